time_base_generator: RTL

Parametrised single-clock time base for the analog clock. Divides the board oscillator into one-cycle second/minute/hour tick enables and maintains a binary hour:minute:second count. Downstream hand-drive logic consumes the ticks as clock enables, never as clocks. Adds run/pause, validated time loading, a 12/24-hour mode and optional 50%-duty square outputs. The whole design stays on `cmosClock`.

---
 rtl/time_base_generator_if.sv | 37 +++
 rtl/time_base_generator.sv | 132 +++++++++++++
 2 files changed

// File: rtl/time_base_generator_if.sv
// Control/status bundle for the analog-clock time base.
// Square outputs exist only when TIME_BASE_SQUARE_OUT_EN is defined.
interface time_base_generator_if;
  logic       run;
  logic       loadEn;
  logic [4:0] loadHour;
  logic [5:0] loadMinute;
  logic [5:0] loadSecond;
  logic       loadError;
  logic       secTick;
  logic       minTick;
  logic       hourTick;
  logic [5:0] second;
  logic [5:0] minute;
  logic [4:0] hour;
`ifdef TIME_BASE_SQUARE_OUT_EN
  logic       secondClock;
  logic       minuteClock;
  logic       hourClock;
`endif

  modport master (
    output run, loadEn, loadHour, loadMinute, loadSecond,
    input  loadError, secTick, minTick, hourTick, second, minute, hour
`ifdef TIME_BASE_SQUARE_OUT_EN
    , input secondClock, minuteClock, hourClock
`endif
  );

  modport slave (
    input  run, loadEn, loadHour, loadMinute, loadSecond,
    output loadError, secTick, minTick, hourTick, second, minute, hour
`ifdef TIME_BASE_SQUARE_OUT_EN
    , output secondClock, minuteClock, hourClock
`endif
  );
endinterface

// File: rtl/time_base_generator.sv
// Single-clock time base: prescaler -> sec/min/hour tick enables and h:m:s count.
// Optional 50%-duty LED square outputs under TIME_BASE_SQUARE_OUT_EN.
module time_base_generator #(
  parameter int CLK_HZ     = 100000000,
  parameter int PRESCALE_W = 27,
  parameter int HOUR_MODE  = 24
) (
  input  logic               cmosClock,
  input  logic               reset,
  time_base_generator_if.slave bus
);

  localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(CLK_HZ - 1);
  localparam logic [4:0] HOUR_FIRST = (HOUR_MODE == 12) ? 5'd1  : 5'd0;
  localparam logic [4:0] HOUR_LAST  = (HOUR_MODE == 12) ? 5'd12 : 5'd23;
  localparam logic [4:0] HOUR_RST   = (HOUR_MODE == 12) ? 5'd12 : 5'd0;

  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [5:0]            sec_q, sec_d;
  logic [5:0]            min_q, min_d;
  logic [4:0]            hr_q,  hr_d;
  logic                  sec_tick_q, sec_tick_d;
  logic                  min_tick_q, min_tick_d;
  logic                  hr_tick_q,  hr_tick_d;
  logic                  load_err_q, load_err_d;
  logic                  hour_ok, load_ok, wrap;

  // 12-hour mode has no hour 0, so the low bound only matters there.
  always_comb begin
    if (HOUR_MODE == 12) hour_ok = (bus.loadHour != 5'd0) && (bus.loadHour <= 5'd12);
    else                 hour_ok = (bus.loadHour <= 5'd23);
  end

  assign load_ok = hour_ok && (bus.loadMinute <= 6'd59) && (bus.loadSecond <= 6'd59);
  assign wrap    = (pre_q == PRE_LAST);

  always_comb begin
    pre_d      = pre_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hr_d       = hr_q;
    sec_tick_d = 1'b0;
    min_tick_d = 1'b0;
    hr_tick_d  = 1'b0;
    load_err_d = 1'b0;
    if (bus.loadEn) begin
      // Load beats a coincident wrap; the pending tick is dropped.
      if (load_ok) begin
        pre_d = '0;
        sec_d = bus.loadSecond;
        min_d = bus.loadMinute;
        hr_d  = bus.loadHour;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (bus.run) begin
      if (wrap) begin
        pre_d      = '0;
        sec_tick_d = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d      = 6'd0;
          min_tick_d = 1'b1;
          if (min_q == 6'd59) begin
            min_d     = 6'd0;
            hr_tick_d = 1'b1;
            hr_d      = (hr_q == HOUR_LAST) ? HOUR_FIRST : hr_q + 5'd1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        pre_d = pre_q + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge cmosClock or posedge reset) begin
    if (reset) begin
      pre_q      <= '0;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      hr_q       <= HOUR_RST;
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
      hr_tick_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      sec_tick_q <= sec_tick_d;
      min_tick_q <= min_tick_d;
      hr_tick_q  <= hr_tick_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.second    = sec_q;
  assign bus.minute    = min_q;
  assign bus.hour      = hr_q;
  assign bus.secTick   = sec_tick_q;
  assign bus.minTick   = min_tick_q;
  assign bus.hourTick  = hr_tick_q;
  assign bus.loadError = load_err_q;

`ifdef TIME_BASE_SQUARE_OUT_EN
  localparam logic [PRESCALE_W-1:0] PRE_HALF = PRESCALE_W'(CLK_HZ / 2);

  logic sclk_q, mclk_q, hclk_q;

  // Derived from next-state so each square flips on the same edge as its counter.
  always_ff @(posedge cmosClock or posedge reset) begin
    if (reset) begin
      sclk_q <= 1'b1;
      mclk_q <= 1'b1;
      hclk_q <= 1'b1;
    end else begin
      sclk_q <= (pre_d < PRE_HALF);
      mclk_q <= (sec_d < 6'd30);
      hclk_q <= (min_d < 6'd30);
    end
  end

  assign bus.secondClock = sclk_q;
  assign bus.minuteClock = mclk_q;
  assign bus.hourClock   = hclk_q;
`endif

endmodule
